// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver with per-word bit order and a valid/ready output slot.
// Define PARITY_CHECK_EN to append and check an even-parity bit after each word.
module sipo_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sin,
  input  logic                        sin_valid,
  input  logic                        msb_first,
  input  logic                        clear,
  output logic [WIDTH-1:0]            y,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic                        overrun,
  output logic                        busy,
  output logic [$clog2(WIDTH+2)-1:0]  bit_count,
  output logic                        parity_err
);

  localparam int CW = $clog2(WIDTH+2);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_shift, w_word, r_y;
  logic [CW-1:0]    r_count;
  logic             r_msb, r_y_valid, r_overrun, r_perr;
  logic             w_msb_eff, w_accept, w_last_data, w_done, w_perr_new, w_slot_free;

  // The first bit of a word uses the live msb_first; later bits use the latched copy.
  assign w_accept     = sin_valid && !clear;
  assign w_msb_eff    = (r_state == S_IDLE) ? msb_first : r_msb;
  assign w_sreg_shift = w_msb_eff ? {r_sreg[WIDTH-2:0], sin} : {sin, r_sreg[WIDTH-1:1]};
  assign w_last_data  = (r_count == CW'(WIDTH-1));
  assign w_slot_free  = !r_y_valid || y_ready;

`ifdef PARITY_CHECK_EN
  assign w_done     = w_accept && (r_state == S_PARITY);
  assign w_word     = r_sreg;
  assign w_perr_new = ^{r_sreg, sin};
`else
  assign w_done     = w_accept && w_last_data;
  assign w_word     = w_sreg_shift;
  assign w_perr_new = 1'b0;
`endif

  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else if (sin_valid) begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_DATA;
`ifdef PARITY_CHECK_EN
        S_DATA:   if (w_last_data) w_state_nxt = S_PARITY;
`else
        S_DATA:   if (w_last_data) w_state_nxt = S_IDLE;
`endif
        S_PARITY: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg    <= '0;
      r_count   <= '0;
      r_msb     <= 1'b0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_overrun <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (clear) begin
        r_sreg  <= '0;
        r_count <= '0;
      end else if (sin_valid) begin
        if (r_state == S_IDLE) r_msb <= msb_first;
        if (w_done) begin
          r_sreg  <= '0;
          r_count <= '0;
        end else begin
          r_sreg  <= w_sreg_shift;
          r_count <= r_count + CW'(1);
        end
      end

      // A completed word either takes the slot or is dropped and flagged.
      if (w_done) begin
        if (w_slot_free) begin
          r_y       <= w_word;
          r_y_valid <= 1'b1;
          r_perr    <= w_perr_new;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_y_valid && y_ready) begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign y          = r_y;
  assign y_valid    = r_y_valid;
  assign overrun    = r_overrun;
  assign parity_err = r_perr;
  assign bit_count  = r_count;
  assign busy       = (r_count != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized plus directed bench for sipo_deserializer against a queue-based word model.
module tb_sipo_deserializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W+2);
`ifdef PARITY_CHECK_EN
  localparam int NB = W + 1;
  localparam bit HAS_PAR = 1'b1;
`else
  localparam int NB = W;
  localparam bit HAS_PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, sin, sin_valid, msb_first, clear, y_ready;
  logic [W-1:0]  y;
  logic          y_valid, overrun, busy, parity_err;
  logic [CW-1:0] bit_count;

  int total = 0;
  int bad   = 0;

  bit           q_bits[$];
  bit           m_msb;
  logic [W-1:0] m_y;
  bit           m_valid, m_ov, m_perr;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .msb_first(msb_first),
    .clear(clear), .y(y), .y_valid(y_valid), .y_ready(y_ready), .overrun(overrun),
    .busy(busy), .bit_count(bit_count), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: collect bits in a queue, build the word by bit position once NB bits arrive.
  task automatic model_update();
    logic [W-1:0] word;
    bit           pe, done;
    done = 1'b0;
    if (rst) begin
      q_bits.delete();
      m_y = '0; m_valid = 1'b0; m_ov = 1'b0; m_perr = 1'b0;
      return;
    end
    if (clear) begin
      q_bits.delete();
    end else if (sin_valid) begin
      if (q_bits.size() == 0) m_msb = msb_first;
      q_bits.push_back(sin);
      if (q_bits.size() == NB) begin
        word = '0;
        pe   = 1'b0;
        for (int i = 0; i < W; i++) begin
          if (m_msb) word[W-1-i] = q_bits[i];
          else       word[i]     = q_bits[i];
        end
        for (int i = 0; i < NB; i++) pe ^= q_bits[i];
        if (!HAS_PAR) pe = 1'b0;
        q_bits.delete();
        done = 1'b1;
        if (!m_valid || y_ready) begin
          m_y = word; m_valid = 1'b1; m_perr = pe;
        end else begin
          m_ov = 1'b1;
        end
      end
    end
    if (!done && m_valid && y_ready) m_valid = 1'b0;
  endtask

  task automatic step(input bit v, input bit s, input bit m, input bit c, input bit r, input bit rs);
    sin_valid = v; sin = s; msb_first = m; clear = c; y_ready = r; rst = rs;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("y",          32'(y),          32'(m_y));
    check("y_valid",    32'(y_valid),    32'(m_valid));
    check("overrun",    32'(overrun),    32'(m_ov));
    check("busy",       32'(busy),       32'(q_bits.size() != 0));
    check("bit_count",  32'(bit_count),  32'(q_bits.size()));
    check("parity_err", 32'(parity_err), 32'(m_perr));
  endtask

  // Sends pattern[W-1] first; the parity bit is only sent when the feature is built in.
  task automatic send_word(input logic [W-1:0] pat, input bit m, input int gap, input bit r,
                           input bit pbit);
    for (int i = W-1; i >= 0; i--) begin
      step(1'b1, pat[i], m, 1'b0, r, 1'b0);
      if (i > 0 || HAS_PAR) repeat (gap) step(1'b0, 1'b0, m, 1'b0, r, 1'b0);
    end
    if (HAS_PAR) step(1'b1, pbit, m, 1'b0, r, 1'b0);
  endtask

  initial begin
    logic [W-1:0] pat;
    sin = 0; sin_valid = 0; msb_first = 0; clear = 0; y_ready = 0; rst = 1;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1);

    // Plain MSB-first word
    pat = 8'hAB;
    send_word(pat, 1'b1, 0, 1'b0, ^pat);
    check("t1_y", 32'(y), 32'h0000_00AB);
    check("t1_valid", 32'(y_valid), 32'd1);
    step(0, 0, 0, 0, 1, 0);

    // LSB-first: same bit stream lands reversed
    send_word(pat, 1'b0, 0, 1'b0, ^pat);
    check("t2_y", 32'(y), 32'h0000_00D5);
    step(0, 0, 0, 0, 1, 0);
    check("t2_drop", 32'(y_valid), 32'd0);

    // Overrun: second word dropped while the first is held
    send_word(8'hAB, 1'b1, 0, 1'b0, 1'b1);
    pat = 8'h55;
    send_word(pat, 1'b1, 0, 1'b0, ^pat);
    check("t3_y", 32'(y), 32'h0000_00AB);
    check("t3_ov", 32'(overrun), 32'd1);
    step(0, 0, 0, 0, 1, 0);
    check("t3_ov_sticky", 32'(overrun), 32'd1);

    // Partial word aborted by clear, then a gapped word
    for (int i = 0; i < 4; i++) step(1, 1'(i), 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    pat = 8'h3C;
    send_word(pat, 1'b1, 2, 1'b0, ^pat);
    check("t4_y", 32'(y), 32'h0000_003C);

    // Reset mid-word wipes everything including overrun
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("t5_ov", 32'(overrun), 32'd0);
    pat = 8'hF0;
    send_word(pat, 1'b1, 0, 1'b0, ^pat);
    check("t5_y", 32'(y), 32'h0000_00F0);
    step(0, 0, 0, 0, 1, 0);

`ifdef PARITY_CHECK_EN
    send_word(8'hAB, 1'b1, 0, 1'b1, 1'b1);
    check("t6_perr_ok", 32'(parity_err), 32'd0);
    send_word(8'hAB, 1'b1, 0, 1'b1, 1'b0);
    check("t6_y", 32'(y), 32'h0000_00AB);
    check("t6_perr_bad", 32'(parity_err), 32'd1);
`endif

    repeat (3000) begin
      step($urandom_range(0, 9) < 6, 1'($urandom), 1'($urandom), $urandom_range(0, 99) < 3,
           $urandom_range(0, 9) < 4, $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in/parallel-out receiver. It assembles a serial bit stream into WIDTH-bit words and presents each word on a parallel output with a valid/ready handshake. It is the receiving end for the team's parallel-load shift registers that shift data out one bit at a time. Bit order is selectable per word, matching the shift-right and shift-left modes.

Parameters:
WIDTH, 8, data word width in bits (valid range 2..32).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
sin  input  1  serial data bit
sin_valid  input  1  sin is sampled on a rising clk edge only when sin_valid=1
msb_first  input  1  bit order; 1 = first bit becomes MSB, 0 = first bit becomes LSB
clear  input  1  synchronous abort of the partially received word
y  output  WIDTH  assembled word
y_valid  output  1  y holds an unconsumed word
y_ready  input  1  consumer accepts y when y_valid && y_ready at a rising edge
overrun  output  1  sticky flag: a completed word was dropped
busy  output  1  a partial word is in progress (bit_count != 0)
bit_count  output  $clog2(WIDTH+2)  number of bits received in the current word
parity_err  output  1  parity status of the word on y (see Optional Feature)

Behaviour:
- Reset: clk, rst=1 → y=0, y_valid=0, overrun=0, busy=0, bit_count=0, parity_err=0, shift register=0, FSM=IDLE. Reset mid-word discards the partial word and any held output word.
- FSM states:
  - IDLE: bit_count=0.
  - DATA: 1..WIDTH-1 bits collected.
  - PARITY: exists only with the macro.
- IDLE + sin_valid → DATA. msb_first is latched on this first bit and held for the whole word; changes mid-word are ignored.
- Shift on each accepted bit:
  - msb_first=1: sreg <= {sreg[WIDTH-2:0], sin}.
  - msb_first=0: sreg <= {sin, sreg[WIDTH-1:1]}.
- sin_valid=0 → sreg and bit_count hold. Arbitrary gaps between bits are legal.
- Word completion: the edge that accepts bit WIDTH (or the parity bit, with the macro).
  - If the output slot is free, or is being accepted on that same edge: y <= assembled word, y_valid=1 from the next cycle (1-cycle latency after the last bit).
  - If y_valid=1 and y_ready=0 on that edge: the new word is dropped, y/y_valid are unchanged, overrun <= 1.
  - In all cases the FSM returns to IDLE and bit_count <= 0.
- Handshake:
  - y_valid && y_ready at an edge with no completion → y_valid <= 0; y retains its last value.
  - Completion and acceptance on the same edge → y loads the new word and y_valid stays 1.
- Back-to-back: a new word's first bit may arrive on the edge immediately after completion.
- clear=1:
  - sreg, bit_count and FSM return to 0/IDLE; the sin bit on that edge is ignored.
  - y, y_valid, overrun and parity_err are unaffected.
  - clear has priority over sin_valid.
- overrun clears only on rst.
- busy = (bit_count != 0).
- Priority: rst > clear > bit shift / completion > handshake.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined: after WIDTH data bits the FSM enters PARITY and the next accepted bit is an even-parity bit (XOR of data bits and parity bit must be 0). bit_count reaches WIDTH before that bit. On completion, parity_err <= computed mismatch and is loaded together with y. The word is delivered even when parity is wrong.
- Undefined: there is no PARITY state, the word completes on bit WIDTH, and parity_err is tied to 0.

Test Plan:
1. WIDTH=8, msb_first=1, serial 1,0,1,0,1,0,1,1 with sin_valid=1, y_ready=0 → one cycle after the 8th bit: y=8'hAB, y_valid=1, busy=0.
2. Same bit sequence with msb_first=0, then y_ready=1 for one cycle → y=8'hD5, y_valid drops after the accepting edge.
3. Two words 8'hAB then 8'h55 (MSB-first), y_ready held at 0 → y stays 8'hAB, y_valid=1, overrun=1. Then pulse y_ready → y_valid=0, overrun remains 1.
4. 4 bits sent, then clear=1, then 8'h3C MSB-first with sin_valid gaps of 2 idle cycles between bits → y=8'h3C, bit_count counts 1..7 and then 0.
5. 5 bits sent, then rst=1 for one cycle → y=0, y_valid=0, bit_count=0, overrun=0. The next full word 8'hF0 is received correctly.
6. PARITY_CHECK_EN defined: 8'hAB followed by parity bit 1 → parity_err=0. 8'hAB followed by parity bit 0 → y=8'hAB, parity_err=1.
